unified_mem_arbiter: RTL and testbench

Single-cycle arbiter sharing one single-ported unified memory (sync read, 1-cycle latency) between the instruction-fetch path and the load/store path of the RV32 core. Grants one access per clock, gives data accesses priority with a bounded-streak anti-starvation rule for fetch, and routes returning read data to the correct requester with a valid strobe. Sits between the PC/instruction-fetch logic and the DataMemory-style storage. Emits a fetch-stall signal used to hold the PC.

---
 rtl/unified_mem_arbiter_if.sv | 38 +++
 rtl/unified_mem_arbiter.sv | 73 +++++++
 tb/tb_unified_mem_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch, load/store and memory-side signals of the unified memory arbiter
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;
    logic              d_req;
    logic              d_we;
    logic [2:0]        d_funct3;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [2:0]        mem_funct3;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_stall, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_funct3, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_stall, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_funct3, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one sync-read memory between fetch and load/store, data first with fetch anti-starvation
module unified_mem_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    unified_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {RD_NONE, RD_IF, RD_D} rd_t;

    rd_t               r_state;
    rd_t               w_next;
    logic [2:0]        r_streak;
    logic              w_if_win;
    logic              w_if_gnt;
    logic              w_d_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // Grants: data wins unless fetch has waited through MAX_DSTREAK data grants; nothing granted in reset
    always_comb begin
        w_if_win = bus.if_req & (~bus.d_req | (r_streak >= 3'(MAX_DSTREAK)));
        w_if_gnt = i_rst_n & w_if_win;
        w_d_gnt  = i_rst_n & bus.d_req & ~w_if_win;
    end

    // Memory port mux: fetch is always a word read, idle drives zeros
    always_comb begin
        w_addr         = w_if_gnt ? bus.if_addr : w_d_gnt ? bus.d_addr : '0;
        w_wdata        = w_d_gnt ? bus.d_wdata : '0;
        bus.if_gnt     = w_if_gnt;
        bus.d_gnt      = w_d_gnt;
        bus.if_stall   = i_rst_n & bus.if_req & ~w_if_gnt;
        bus.mem_en     = w_if_gnt | w_d_gnt;
        bus.mem_we     = w_d_gnt & bus.d_we;
        bus.mem_funct3 = w_if_gnt ? 3'b010 : w_d_gnt ? bus.d_funct3 : 3'b000;
        bus.mem_addr   = w_addr;
        bus.mem_wdata  = w_wdata;
    end

    // Count data grants that pass over a waiting fetch, saturating at 7
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_streak <= '0;
        else if (!bus.if_req || w_if_gnt)
            r_streak <= '0;
        else if (w_d_gnt && r_streak != 3'd7)
            r_streak <= r_streak + 3'd1;
    end

    // Return FSM state register: remembers who owns the read data arriving next cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= RD_NONE;
        else
            r_state <= w_next;
    end

    // Return FSM next state: only reads leave something outstanding
    always_comb begin
        w_next = w_if_gnt ? RD_IF : (w_d_gnt & ~bus.d_we) ? RD_D : RD_NONE;
    end

    // Return FSM outputs: steer memory read data to its owner, zero elsewhere
    always_comb begin
        bus.if_rvalid = (r_state == RD_IF);
        bus.d_rvalid  = (r_state == RD_D);
        bus.if_rdata  = (r_state == RD_IF) ? bus.mem_rdata : '0;
        bus.d_rdata   = (r_state == RD_D) ? bus.mem_rdata : '0;
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: cycle-by-cycle directed vectors for the unified memory arbiter
module tb_unified_mem_arbiter;
    typedef struct {
        logic        rst_n;
        logic        ifr;
        logic [7:0]  ifa;
        logic        dr;
        logic        dwe;
        logic [2:0]  df3;
        logic [7:0]  da;
        logic [31:0] dwd;
        logic [31:0] mrd;
        logic [113:0] exp;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    logic p_if = 1'b0;
    logic p_d = 1'b0;
    vec_t tbl[$];

    unified_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    unified_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_DSTREAK(2)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [113:0] pk(logic ig, logic dg, logic st, logic irv, logic drv, logic men,
                                        logic mwe, logic [2:0] mf3, logic [7:0] ma, logic [31:0] ird,
                                        logic [31:0] drd, logic [31:0] mwd);
        return {ig, dg, st, irv, drv, men, mwe, mf3, ma, ird, drd, mwd};
    endfunction

    function automatic vec_t mk(logic r, logic ifr, logic [7:0] ifa, logic dr, logic dwe, logic [2:0] df3,
                                logic [7:0] da, logic [31:0] dwd, logic [31:0] mrd,
                                logic ig, logic dg, logic st, logic irv, logic drv, logic men, logic mwe,
                                logic [2:0] mf3, logic [7:0] ma, logic [31:0] ird, logic [31:0] drd,
                                logic [31:0] mwd);
        vec_t v;
        v.rst_n = r; v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.dwe = dwe; v.df3 = df3;
        v.da = da; v.dwd = dwd; v.mrd = mrd;
        v.exp = pk(ig, dg, st, irv, drv, men, mwe, mf3, ma, ird, drd, mwd);
        return v;
    endfunction

    task automatic apply(input string name, input vec_t v);
        logic [113:0] act;
        @(posedge i_clk);
        #1;
        i_rst_n = v.rst_n;
        bus.if_req = v.ifr; bus.if_addr = v.ifa;
        bus.d_req = v.dr; bus.d_we = v.dwe; bus.d_funct3 = v.df3; bus.d_addr = v.da; bus.d_wdata = v.dwd;
        bus.mem_rdata = v.mrd;
        #3;
        act = pk(bus.if_gnt, bus.d_gnt, bus.if_stall, bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we,
                 bus.mem_funct3, bus.mem_addr, bus.if_rdata, bus.d_rdata, bus.mem_wdata);
        n_vec++;
        if (act !== v.exp) begin
            n_bad++;
            $display("FAIL %s: outputs got %h expected %h", name, act, v.exp);
        end
    endtask

    // A request may only be withdrawn without a grant while reset is asserted
    always @(negedge i_clk) begin
        if (i_rst_n && ((p_if && !bus.if_req) || (p_d && !bus.d_req))) begin
            n_bad++;
            $display("FAIL protocol: request dropped without grant got drop expected hold");
        end
        p_if = i_rst_n & bus.if_req & ~bus.if_gnt;
        p_d  = i_rst_n & bus.d_req & ~bus.d_gnt;
    end

    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_funct3 = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
        tbl.push_back(mk(0,1,8'h10,1,0,3'b010,8'h20,0,0,                 0,0,0,0,0,0,0,3'd0,8'h00,0,0,0));
        tbl.push_back(mk(0,1,8'h10,1,0,3'b010,8'h20,0,0,                 0,0,0,0,0,0,0,3'd0,8'h00,0,0,0));
        tbl.push_back(mk(1,1,8'h10,1,0,3'b010,8'h20,0,0,                 0,1,1,0,0,1,0,3'd2,8'h20,0,0,0));
        tbl.push_back(mk(1,1,8'h10,1,0,3'b010,8'h20,0,32'hAAAA0001,      0,1,1,0,1,1,0,3'd2,8'h20,0,32'hAAAA0001,0));
        tbl.push_back(mk(1,1,8'h10,1,0,3'b010,8'h20,0,32'hAAAA0002,      1,0,0,0,1,1,0,3'd2,8'h10,0,32'hAAAA0002,0));
        tbl.push_back(mk(1,1,8'h10,1,0,3'b010,8'h20,0,32'h11111111,      0,1,1,1,0,1,0,3'd2,8'h20,32'h11111111,0,0));
        tbl.push_back(mk(1,1,8'h10,1,0,3'b010,8'h20,0,32'hAAAA0003,      0,1,1,0,1,1,0,3'd2,8'h20,0,32'hAAAA0003,0));
        tbl.push_back(mk(1,1,8'h10,1,0,3'b010,8'h20,0,32'hAAAA0004,      1,0,0,0,1,1,0,3'd2,8'h10,0,32'hAAAA0004,0));
        tbl.push_back(mk(1,0,8'h10,1,0,3'b010,8'h20,0,32'h22222222,      0,1,0,1,0,1,0,3'd2,8'h20,32'h22222222,0,0));
        tbl.push_back(mk(1,0,8'h10,1,1,3'b010,8'h04,32'hDEADBEEF,32'hAAAA0005, 0,1,0,0,1,1,1,3'd2,8'h04,0,32'hAAAA0005,32'hDEADBEEF));
        tbl.push_back(mk(1,0,8'h10,1,0,3'b010,8'h04,0,0,                 0,1,0,0,0,1,0,3'd2,8'h04,0,0,0));
        tbl.push_back(mk(1,1,8'h10,0,0,3'b010,8'h04,0,32'hDEADBEEF,      1,0,0,0,1,1,0,3'd2,8'h10,0,32'hDEADBEEF,0));
        tbl.push_back(mk(1,1,8'h10,0,0,3'b010,8'h04,0,32'h00500093,      1,0,0,1,0,1,0,3'd2,8'h10,32'h00500093,0,0));
        tbl.push_back(mk(1,1,8'h10,0,0,3'b010,8'h04,0,32'h00500093,      1,0,0,1,0,1,0,3'd2,8'h10,32'h00500093,0,0));
        tbl.push_back(mk(1,0,8'h10,1,0,3'b100,8'h08,0,32'h00500093,      0,1,0,1,0,1,0,3'd4,8'h08,32'h00500093,0,0));
        tbl.push_back(mk(1,1,8'h14,0,0,3'b100,8'h08,0,32'h12345678,      1,0,0,0,1,1,0,3'd2,8'h14,0,32'h12345678,0));
        tbl.push_back(mk(1,0,8'h14,0,0,3'b010,8'h08,0,32'h9ABCDEF0,      0,0,0,1,0,0,0,3'd0,8'h00,32'h9ABCDEF0,0,0));
        tbl.push_back(mk(1,0,8'h14,0,0,3'b010,8'h08,0,32'h55555555,      0,0,0,0,0,0,0,3'd0,8'h00,0,0,0));
        for (int i = 0; i < tbl.size(); i++)
            apply($sformatf("vec%0d", i), tbl[i]);
        apply("midrd_fetch",   mk(1,1,8'h10,0,0,3'b010,8'h00,0,0,            1,0,0,0,0,1,0,3'd2,8'h10,0,0,0));
        apply("midrd_reset",   mk(0,1,8'h10,0,0,3'b010,8'h00,0,32'h77777777, 0,0,0,0,0,0,0,3'd0,8'h00,0,0,0));
        apply("midrd_release", mk(1,0,8'h10,0,0,3'b010,8'h00,0,32'h77777777, 0,0,0,0,0,0,0,3'd0,8'h00,0,0,0));
        apply("midrd_idle",    mk(1,0,8'h10,0,0,3'b010,8'h00,0,32'h77777777, 0,0,0,0,0,0,0,3'd0,8'h00,0,0,0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
